// File: rtl/i2c_adc_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_adc_seq
//  Description : Command sequencer for an I2C ADC behind a byte-level I2C
//                engine. After enable it writes CFG_WORD to ADC register 0x01,
//                points the ADC at register 0x00, then polls conversions
//                forever: read two bytes, wait POLL_GAP clocks, read again.
//
//  Ports       : clk, rst_n (async, active-low), en (run enable)
//                i2c_go / i2c_cmd / i2c_wdata  -> command to the byte engine
//                i2c_rdata / i2c_busy          <- status from the byte engine
//                sample, sample_valid, conv_cnt -> conversion results
//                active                         -> sequencer not idle
//
//  Options     : ADC_AVG_EN - when defined, four consecutive reads are
//                averaged and one result is published per four reads.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_adc_seq #(
    parameter logic [6:0]  DEV_ADDR = 7'h48,
    parameter logic [15:0] CFG_WORD = 16'hC383,
    parameter logic [15:0] POLL_GAP = 16'd12000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        i2c_go,
    output logic [2:0]  i2c_cmd,
    output logic [7:0]  i2c_wdata,
    input  logic [7:0]  i2c_rdata,
    input  logic        i2c_busy,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic [15:0] conv_cnt,
    output logic        active
);

    localparam logic [2:0] C_CMD_START     = 3'd1;
    localparam logic [2:0] C_CMD_SEND      = 3'd2;
    localparam logic [2:0] C_CMD_RECV_ACK  = 3'd3;
    localparam logic [2:0] C_CMD_RECV_NACK = 3'd4;
    localparam logic [2:0] C_CMD_STOP      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_step;
    logic [3:0]  w_step_nxt;
    logic [1:0]  r_wait;
    logic [15:0] r_gap;
    logic        w_done;
    logic        w_on_bus;
    logic [2:0]  w_cmd;
    logic [7:0]  w_wdata;

    // Fixed program: config write (0-5), pointer write (6-9), read (10-14).
    always_comb begin
        w_cmd   = 3'd0;
        w_wdata = 8'h00;
        case (r_step)
            4'd0, 4'd6, 4'd10: w_cmd = C_CMD_START;
            4'd1, 4'd7: begin
                w_cmd   = C_CMD_SEND;
                w_wdata = {DEV_ADDR, 1'b0};
            end
            4'd2: begin
                w_cmd   = C_CMD_SEND;
                w_wdata = 8'h01;
            end
            4'd3: begin
                w_cmd   = C_CMD_SEND;
                w_wdata = CFG_WORD[15:8];
            end
            4'd4: begin
                w_cmd   = C_CMD_SEND;
                w_wdata = CFG_WORD[7:0];
            end
            4'd8: begin
                w_cmd   = C_CMD_SEND;
                w_wdata = 8'h00;
            end
            4'd11: begin
                w_cmd   = C_CMD_SEND;
                w_wdata = {DEV_ADDR, 1'b1};
            end
            4'd12:             w_cmd = C_CMD_RECV_ACK;
            4'd13:             w_cmd = C_CMD_RECV_NACK;
            4'd5, 4'd9, 4'd14: w_cmd = C_CMD_STOP;
            default: ;
        endcase
    end

    // Command fields are held from the go pulse until the step completes.
    assign w_on_bus  = (r_state == S_ISSUE) || (r_state == S_WAIT_HI) ||
                       (r_state == S_WAIT_LO);
    assign i2c_go    = (r_state == S_ISSUE);
    assign i2c_cmd   = w_on_bus ? w_cmd : 3'd0;
    assign i2c_wdata = w_on_bus ? w_wdata : 8'h00;
    assign active    = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_step_nxt = 4'd0;
                if (en) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: w_state_nxt = S_WAIT_HI;
            S_WAIT_HI: begin
                // Engine missed the pulse: re-issue the same step.
                if (i2c_busy)             w_state_nxt = S_WAIT_LO;
                else if (r_wait == 2'd3)  w_state_nxt = S_ISSUE;
            end
            S_WAIT_LO: begin
                if (!i2c_busy) begin
                    w_done = 1'b1;
                    if (r_step == 4'd14) begin
                        w_state_nxt = S_GAP;
                    end else if ((r_step == 4'd5 || r_step == 4'd9) && !en) begin
                        // Only stop at a STOP boundary so the bus is never left open.
                        w_state_nxt = S_IDLE;
                        w_step_nxt  = 4'd0;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_step_nxt  = r_step + 4'd1;
                    end
                end
            end
            S_GAP: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                    w_step_nxt  = 4'd0;
                end else if (r_gap <= 16'd1) begin
                    // GAP itself takes one cycle, so a count of N gives N cycles
                    // here and a count of 0 still leaves after one.
                    w_state_nxt = S_ISSUE;
                    w_step_nxt  = 4'd6;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_step_nxt  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_step  <= 4'd0;
            r_wait  <= 2'd0;
            r_gap   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_wait  <= (r_state == S_WAIT_HI) ? r_wait + 2'd1 : 2'd0;
            if (w_done && r_step == 4'd14)
                r_gap <= POLL_GAP;
            else if (r_state == S_GAP)
                r_gap <= (r_gap <= 16'd1 || !en) ? 16'd0 : r_gap - 16'd1;
        end
    end

`ifdef ADC_AVG_EN
    logic [17:0] r_acc;
    logic [1:0]  r_phase;
    logic [15:0] r_read;
    logic [17:0] w_acc_sum;

    assign w_acc_sum = r_acc + {2'b00, r_read};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= 16'h0000;
            sample_valid <= 1'b0;
            conv_cnt     <= 16'h0000;
            r_acc        <= 18'd0;
            r_phase      <= 2'd0;
            r_read       <= 16'h0000;
        end else begin
            sample_valid <= 1'b0;
            if (r_state == S_IDLE && en) begin
                r_acc   <= 18'd0;
                r_phase <= 2'd0;
            end
            if (w_done) begin
                case (r_step)
                    4'd12: r_read[15:8] <= i2c_rdata;
                    4'd13: r_read[7:0]  <= i2c_rdata;
                    4'd14: begin
                        r_phase <= r_phase + 2'd1;
                        if (r_phase == 2'd3) begin
                            sample       <= w_acc_sum[17:2];
                            sample_valid <= 1'b1;
                            conv_cnt     <= conv_cnt + 16'd1;
                            r_acc        <= 18'd0;
                        end else begin
                            r_acc <= w_acc_sum;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= 16'h0000;
            sample_valid <= 1'b0;
            conv_cnt     <= 16'h0000;
        end else begin
            sample_valid <= 1'b0;
            if (w_done) begin
                case (r_step)
                    4'd12: sample[15:8] <= i2c_rdata;
                    4'd13: sample[7:0]  <= i2c_rdata;
                    4'd14: begin
                        sample_valid <= 1'b1;
                        conv_cnt     <= conv_cnt + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_adc_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_adc_seq
//  Description : Self-checking bench for i2c_adc_seq with a byte-engine model
//                (busy one cycle after go, 20 cycles long).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_adc_seq;

    localparam int BUSY_LEN = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        i2c_go;
    logic [2:0]  i2c_cmd;
    logic [7:0]  i2c_wdata;
    logic [7:0]  i2c_rdata;
    logic        i2c_busy;
    logic [15:0] sample;
    logic        sample_valid;
    logic [15:0] conv_cnt;
    logic        active;

    i2c_adc_seq #(
        .DEV_ADDR (7'h48),
        .CFG_WORD (16'hC383),
        .POLL_GAP (16'd5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .i2c_go       (i2c_go),
        .i2c_cmd      (i2c_cmd),
        .i2c_wdata    (i2c_wdata),
        .i2c_rdata    (i2c_rdata),
        .i2c_busy     (i2c_busy),
        .sample       (sample),
        .sample_valid (sample_valid),
        .conv_cnt     (conv_cnt),
        .active       (active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- byte-engine model ----------------
    logic [7:0] rd_vals [16];
    int m_idx    = 0;
    int r_idx    = 0;
    int drop_idx = -1;
    int bcnt     = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i2c_busy <= 1'b0;
            bcnt     <= 0;
        end else if (i2c_go) begin
            m_idx <= m_idx + 1;
            if (m_idx != drop_idx) begin
                i2c_busy <= 1'b1;
                bcnt     <= BUSY_LEN - 1;
                if (i2c_cmd == 3'd3 || i2c_cmd == 3'd4) begin
                    i2c_rdata <= rd_vals[r_idx % 16];
                    r_idx     <= r_idx + 1;
                end
            end
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
        end else begin
            i2c_busy <= 1'b0;
        end
    end

    // ---------------- monitor ----------------
    typedef struct {
        int         cyc;
        logic [2:0] cmd;
        logic [7:0] wd;
    } go_t;
    go_t go_q[$];
    int  sv_q[$];

    always @(negedge clk) begin
        if (rst_n && i2c_go) go_q.push_back('{cyc, i2c_cmd, i2c_wdata});
        if (rst_n && sample_valid) sv_q.push_back(cyc);
    end

    function automatic go_t go_at(input int i);
        go_t g;
        g = '{-1000, 3'd7, 8'hEE};
        if (i < go_q.size()) g = go_q[i];
        return g;
    endfunction

    function automatic int sv_at(input int i);
        return (i < sv_q.size()) ? sv_q[i] : -1000;
    endfunction

    // ---------------- checking helpers ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_gos(input int n, input string nm);
        int k = 0;
        while (go_q.size() < n && k < 4000) begin
            tick();
            k++;
        end
        chk(nm, 32'(go_q.size() >= n), 32'd1);
    endtask

    task automatic wait_svs(input int n, input string nm);
        int k = 0;
        while (sv_q.size() < n && k < 8000) begin
            tick();
            k++;
        end
        chk(nm, 32'(sv_q.size() >= n), 32'd1);
    endtask

    typedef struct {
        logic [2:0] cmd;
        logic [7:0] wd;
        bit         send;
    } vec_t;

    vec_t prog [15];
    int   base;

    initial begin
        // Expected program for DEV_ADDR=0x48, CFG_WORD=0xC383.
        prog[0]  = '{3'd1, 8'h00, 1'b0};
        prog[1]  = '{3'd2, 8'h90, 1'b1};
        prog[2]  = '{3'd2, 8'h01, 1'b1};
        prog[3]  = '{3'd2, 8'hC3, 1'b1};
        prog[4]  = '{3'd2, 8'h83, 1'b1};
        prog[5]  = '{3'd5, 8'h00, 1'b0};
        prog[6]  = '{3'd1, 8'h00, 1'b0};
        prog[7]  = '{3'd2, 8'h90, 1'b1};
        prog[8]  = '{3'd2, 8'h00, 1'b1};
        prog[9]  = '{3'd5, 8'h00, 1'b0};
        prog[10] = '{3'd1, 8'h00, 1'b0};
        prog[11] = '{3'd2, 8'h91, 1'b1};
        prog[12] = '{3'd3, 8'h00, 1'b0};
        prog[13] = '{3'd4, 8'h00, 1'b0};
        prog[14] = '{3'd5, 8'h00, 1'b0};

        for (int i = 0; i < 16; i++) rd_vals[i] = 8'h00;
`ifdef ADC_AVG_EN
        // 100, 200, 300, 401 -> mean 250 (truncated)
        rd_vals[0] = 8'h00; rd_vals[1] = 8'h64;
        rd_vals[2] = 8'h00; rd_vals[3] = 8'hC8;
        rd_vals[4] = 8'h01; rd_vals[5] = 8'h2C;
        rd_vals[6] = 8'h01; rd_vals[7] = 8'h91;
`else
        rd_vals[0] = 8'h12; rd_vals[1] = 8'h34;
        rd_vals[2] = 8'hAB; rd_vals[3] = 8'hCD;
`endif

        // ---- reset state ----
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) tick();
        chk("rst_go",     32'(i2c_go),       32'd0);
        chk("rst_cmd",    32'(i2c_cmd),      32'd0);
        chk("rst_wdata",  32'(i2c_wdata),    32'd0);
        chk("rst_sample", 32'(sample),       32'd0);
        chk("rst_valid",  32'(sample_valid), 32'd0);
        chk("rst_cnt",    32'(conv_cnt),     32'd0);
        chk("rst_active", 32'(active),       32'd0);

        rst_n = 1'b1;

`ifdef ADC_AVG_EN
        // ---- four reads averaged into one result ----
        wait_svs(1, "avg_valid_timeout");
        chk("avg_sample",   32'(sample),      32'd250);
        chk("avg_cnt",      32'(conv_cnt),    32'd1);
        chk("avg_pulses",   32'(sv_q.size()), 32'd1);
        // 15 steps for the first read, 9 for each of the next three.
        chk("avg_go_count", 32'(go_q.size()), 32'd42);
`else
        // ---- first read ----
        wait_svs(1, "rd1_valid_timeout");
        chk("rd1_sample",   32'(sample),      32'h1234);
        chk("rd1_cnt",      32'(conv_cnt),    32'd1);
        chk("rd1_pulses",   32'(sv_q.size()), 32'd1);
        chk("rd1_go_count", 32'(go_q.size()), 32'd15);
`endif

        // ---- program order (table) ----
        for (int i = 0; i < 15; i++) begin
            go_t g;
            g = go_at(i);
            chk($sformatf("prog_cmd[%0d]", i), 32'(g.cmd), 32'(prog[i].cmd));
            if (prog[i].send)
                chk($sformatf("prog_wdata[%0d]", i), 32'(g.wd), 32'(prog[i].wd));
        end

`ifndef ADC_AVG_EN
        // ---- gap length: POLL_GAP=5 GAP cycles before the step-6 go ----
        drop_idx = 18;                 // engine will ignore the step-9 STOP
        wait_gos(16, "gap_go_timeout");
        chk("gap_cycles", 32'(go_at(15).cyc - sv_at(0)), 32'd5);
        chk("gap_cmd",    32'(go_at(15).cmd),            32'd1);

        // ---- missing busy: same STOP re-pulsed after 4 WAIT_HI clocks ----
        wait_gos(22, "retry_go_timeout");
        chk("retry_cmd0",  32'(go_at(18).cmd), 32'd5);
        chk("retry_cmd1",  32'(go_at(19).cmd), 32'd5);
        chk("retry_delay", 32'(go_at(19).cyc - go_at(18).cyc), 32'd5);
        chk("retry_next",  32'(go_at(20).cmd), 32'd1);
        chk("hold_sample", 32'(sample), 32'h1234);

        // ---- en dropped while step 11 is issued ----
        chk("step11_wd", 32'(go_at(21).wd), 32'h91);
        en = 1'b0;
        wait_svs(2, "rd2_valid_timeout");
        chk("rd2_sample", 32'(sample),   32'hABCD);
        chk("rd2_cnt",    32'(conv_cnt), 32'd2);
        repeat (40) tick();
        chk("stop_go_count", 32'(go_q.size()),    32'd25);
        chk("stop_last_cmd", 32'(go_at(24).cmd),  32'd5);
        chk("stop_active",   32'(active),         32'd0);

        // ---- re-enable restarts with the config write ----
        en = 1'b1;
        wait_gos(28, "reen_go_timeout");
        chk("reen_cmd", 32'(go_at(25).cmd), 32'd1);
        chk("reen_wd1", 32'(go_at(26).wd),  32'h90);
        chk("reen_wd2", 32'(go_at(27).wd),  32'h01);

        // ---- reset mid-transaction ----
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_active", 32'(active),   32'd0);
        chk("mrst_go",     32'(i2c_go),   32'd0);
        chk("mrst_cnt",    32'(conv_cnt), 32'd0);
        chk("mrst_sample", 32'(sample),   32'd0);
        base  = go_q.size();
        rst_n = 1'b1;
        wait_gos(base + 3, "mrst_go_timeout");
        chk("mrst_cmd", 32'(go_at(base).cmd),    32'd1);
        chk("mrst_wd2", 32'(go_at(base + 2).wd), 32'h01);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
